// File: rtl/display_pkg.sv
// Shared definitions for the BCD display formatter.
// Holds the segment byte constants, the DP bit position, the largest
// displayable value and the formatter's state encoding.
package display_pkg;

    // Largest value the four digits can show
    localparam int unsigned MAX_DISPLAY_VALUE = 9999;

    // Segment byte layout is {a,b,c,d,e,f,g,DP}; DP sits in the LSB
    localparam int DP_BIT = 0;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h02;

    // Index n holds the glyph for decimal digit n
    localparam logic [9:0][7:0] SEG_DIGIT = {
        8'hF6, 8'hFE, 8'hE0, 8'hBE, 8'hB6,
        8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    // State encoding
    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_CONVERT = 2'd1;
    localparam logic [1:0] STATE_ENCODE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = STATE_IDLE,
        S_CONVERT = STATE_CONVERT,
        S_ENCODE  = STATE_ENCODE
    } state_t;

endpackage

// File: rtl/seg7_encoder.sv
// seg7_encoder: combinational BCD nibble to 7-segment byte.
// Ports:
//   i_bcd   - BCD digit 0..9 (codes 10..15 render blank)
//   i_blank - 1 = suppress the digit glyph
//   i_dp    - 1 = light the decimal point (lit even when blanked)
//   o_seg   - {a,b,c,d,e,f,g,DP}, 1 = segment lit
module seg7_encoder
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    logic [7:0] w_glyph;

    always_comb begin
        w_glyph = SEG_BLANK;
        case (i_bcd)
            4'd0:    w_glyph = SEG_DIGIT[0];
            4'd1:    w_glyph = SEG_DIGIT[1];
            4'd2:    w_glyph = SEG_DIGIT[2];
            4'd3:    w_glyph = SEG_DIGIT[3];
            4'd4:    w_glyph = SEG_DIGIT[4];
            4'd5:    w_glyph = SEG_DIGIT[5];
            4'd6:    w_glyph = SEG_DIGIT[6];
            4'd7:    w_glyph = SEG_DIGIT[7];
            4'd8:    w_glyph = SEG_DIGIT[8];
            4'd9:    w_glyph = SEG_DIGIT[9];
            default: w_glyph = SEG_BLANK;
        endcase

        o_seg         = i_blank ? SEG_BLANK : w_glyph;
        o_seg[DP_BIT] = o_seg[DP_BIT] | i_dp;
    end

endmodule

// File: rtl/bcd_display_formatter.sv
// bcd_display_formatter: converts a binary value to four 7-segment bytes
// for the display controller, using a sequential double-dabble engine.
// Ports:
//   i_clk, i_reset      - clock, synchronous active-high reset
//   i_value_stb         - request; sampled only while idle
//   i_value             - binary value to show (0..9999)
//   i_dp                - decimal-point flags, bit n -> digit Dn
//   o_busy              - conversion in progress, strobes dropped
//   o_done_stb          - one-cycle pulse after the display registers update
//   o_overflow          - last accepted value exceeded 9999
//   o_display_D0..D3    - segment bytes {a,b,c,d,e,f,g,DP}
module bcd_display_formatter
    import display_pkg::*;
#(
    parameter int VALUE_WIDTH         = 14,
    parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_value_stb,
    input  logic [VALUE_WIDTH-1:0] i_value,
    input  logic [3:0]             i_dp,
    output logic                   o_busy,
    output logic                   o_done_stb,
    output logic                   o_overflow,
    output logic [7:0]             o_display_D0,
    output logic [7:0]             o_display_D1,
    output logic [7:0]             o_display_D2,
    output logic [7:0]             o_display_D3
);

    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [VALUE_WIDTH-1:0] r_bin;
    logic [15:0]            r_bcd;
    logic [CNT_W-1:0]       r_cnt;
    logic [3:0]             r_dp;
    logic                   r_ovf_pend;
    logic                   r_overflow;
    logic                   r_done;
    logic [3:0][7:0]        r_disp;

    logic                   w_accept;
    logic                   w_value_ovf;
    logic [15:0]            w_bcd_adj;
    logic [3:0]             w_blank;
    logic [3:0][7:0]        w_seg;

    assign w_accept    = (r_state == S_IDLE) && i_value_stb;
    assign w_value_ovf = 32'(i_value) > 32'(MAX_DISPLAY_VALUE);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (i_value_stb) w_next_state = S_CONVERT;
            // Counter still holds 1 while the last shift happens
            S_CONVERT: if (r_cnt == CNT_W'(1)) w_next_state = S_ENCODE;
            S_ENCODE:  w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // ---------------- double dabble datapath ----------------
    // Add-3 correction on every nibble >= 5, applied before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int n = 0; n < 4; n++) begin
            if (r_bcd[4*n +: 4] >= 4'd5)
                w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_dp       <= '0;
            r_ovf_pend <= 1'b0;
        end else if (w_accept) begin
            r_bin      <= i_value;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(VALUE_WIDTH);
            r_dp       <= i_dp;
            r_ovf_pend <= w_value_ovf;
        end else if (r_state == S_CONVERT) begin
            r_bcd <= {w_bcd_adj[14:0], r_bin[VALUE_WIDTH-1]};
            r_bin <= {r_bin[VALUE_WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // ---------------- segment encoding ----------------
    // A leading digit blanks only when it and every digit above it are zero
    always_comb begin
        w_blank = 4'b0000;
        if (BLANK_LEADING_ZEROS) begin
            w_blank[3] = (r_bcd[15:12] == 4'd0);
            w_blank[2] = w_blank[3] && (r_bcd[11:8] == 4'd0);
            w_blank[1] = w_blank[2] && (r_bcd[7:4]  == 4'd0);
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_digit
            seg7_encoder u_enc (
                .i_bcd   (r_bcd[4*g +: 4]),
                .i_blank (w_blank[g]),
                .i_dp    (r_dp[g]),
                .o_seg   (w_seg[g])
            );
        end
    endgenerate

    // Display registers only move in ENCODE so the scan never sees
    // a half-converted value
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_disp     <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_ENCODE);
            if (r_state == S_ENCODE) begin
                r_overflow <= r_ovf_pend;
                for (int n = 0; n < 4; n++)
                    r_disp[n] <= r_ovf_pend ? SEG_DASH : w_seg[n];
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done_stb   = r_done;
    assign o_overflow   = r_overflow;
    assign o_display_D0 = r_disp[0];
    assign o_display_D1 = r_disp[1];
    assign o_display_D2 = r_disp[2];
    assign o_display_D3 = r_disp[3];

endmodule
